// File: rtl/spi_ram_bridge_if.sv
// spi_ram_bridge_if -- serial-side signal bundle of the SPI-to-RAM bridge.
//
// Signals:
//   ss_n      : slave select, active low, frames a transaction (master -> bridge)
//   MOSI      : serial data in, MSB first                      (master -> bridge)
//   MISO      : serial data out, MSB first                     (bridge -> master)
//   busy      : high while a frame is in progress              (bridge -> master)
//   frame_err : one-cycle pulse after a frame aborted mid-field (bridge -> master)
interface spi_ram_bridge_if;
    logic ss_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_err;

    modport master (output ss_n, output MOSI, input MISO, input busy, input frame_err);
    modport slave  (input ss_n, input MOSI, output MISO, output busy, output frame_err);
endinterface

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge -- SPI slave in front of a single-port RAM.
//
// Frames (while ss_n is low, MSB first, all sampled on the rising clk edge):
//   cmd 00 + address : load write pointer
//   cmd 10 + address : load read pointer
//   cmd 01 + words   : write words at the write pointer
//   cmd 11           : stream words from the read pointer on MISO
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : spi_ram_bridge_if.slave (ss_n, MOSI in; MISO, busy, frame_err out)
//
// Parameters: MEM_DEPTH (words, <= 2**ADDR_W), ADDR_W, DATA_W (>= 2).
//
// Build option: define SPI_RAM_BURST_EN for burst auto-increment (back-to-back
// words in one frame). Without it a write or read frame moves exactly one word
// and then holds until ss_n rises.
module spi_ram_bridge #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_bridge_if.slave bus
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  FETCH_BIT = CNT_W'(DATA_W - 2);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(MEM_DEPTH - 1);

`ifdef SPI_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, RD_FETCH, RD_SHIFT} state_t;

    state_t            state, state_n;
    logic [1:0]        cmd;
    logic [CNT_W-1:0]  bit_cnt;     // bits received; in RD_SHIFT, index of the bit on MISO
    logic              hold;        // field done, ignore MOSI until ss_n rises
    logic              rd_load;     // fetched word waiting to be put on MISO
    logic [MAX_W-2:0]  in_sr;
    logic [MAX_W-1:0]  shift_in;    // received bits including the one on MOSI now
    logic [DATA_W-2:0] out_sr;      // remaining bits of the word on MISO
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              miso_q, frame_err_q;
    logic              abort, mid_field, field_last, mem_we, rd_en;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Pointers wrap after the last word and from any out-of-range value.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p >= PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign shift_in      = {in_sr, bus.MOSI};
    assign abort         = (state != IDLE) && bus.ss_n;
    assign bus.MISO      = miso_q;
    assign bus.busy      = (state != IDLE);
    assign bus.frame_err = frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n    = state;
        mid_field  = 1'b0;
        field_last = 1'b0;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        if (abort) begin
            state_n   = IDLE;
            // Word boundaries, the address hold and read states end cleanly.
            mid_field = (state == CMD) || (state == ADDR && !hold) ||
                        (state == WRITE && !hold && bit_cnt != '0);
        end else begin
            unique case (state)
                IDLE: if (!bus.ss_n) state_n = CMD;
                CMD: begin
                    if (bit_cnt != '0) begin
                        case ({cmd[0], bus.MOSI})
                            2'b01:   state_n = WRITE;
                            2'b11:   state_n = RD_FETCH;
                            default: state_n = ADDR;
                        endcase
                    end
                end
                ADDR: field_last = !hold && (bit_cnt == ADDR_LAST);
                WRITE: begin
                    field_last = !hold && (bit_cnt == DATA_LAST);
                    mem_we     = field_last && (wr_ptr <= PTR_LAST);
                end
                RD_FETCH: begin
                    rd_en   = 1'b1;
                    state_n = RD_SHIFT;
                end
                // Prefetch the next word while bit DATA_W-2 is on MISO.
                RD_SHIFT: rd_en = BURST && !rd_load && !hold && (bit_cnt == FETCH_BIT);
                default:  state_n = IDLE;
            endcase
        end
    end

    // NOTE: the RAM array and its read register are never reset; rst only
    // blocks a write that lands on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[wr_ptr[IDX_W-1:0]] <= shift_in[DATA_W-1:0];
        if (rd_en) rd_data <= (rd_ptr <= PTR_LAST) ? mem[rd_ptr[IDX_W-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd         <= '0;
            bit_cnt     <= '0;
            hold        <= 1'b0;
            rd_load     <= 1'b0;
            in_sr       <= '0;
            out_sr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in clocked logic, so
            // every register sees the pre-edge value of every other register.
            frame_err_q <= mid_field;
            miso_q      <= 1'b0;
            if (abort || state == IDLE) begin
                bit_cnt <= '0;
                hold    <= 1'b0;
                rd_load <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        cmd     <= {cmd[0], bus.MOSI};
                        bit_cnt <= (bit_cnt != '0) ? '0 : bit_cnt + 1'b1;
                    end
                    ADDR: begin
                        if (!hold) begin
                            in_sr <= shift_in[MAX_W-2:0];
                            if (field_last) begin
                                hold <= 1'b1;
                                if (cmd[1]) rd_ptr <= shift_in[ADDR_W-1:0];
                                else        wr_ptr <= shift_in[ADDR_W-1:0];
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        if (!hold) begin
                            in_sr <= shift_in[MAX_W-2:0];
                            if (field_last) begin
                                bit_cnt <= '0;
                                hold    <= !BURST;
                                wr_ptr  <= ptr_inc(wr_ptr);
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    RD_FETCH: begin
                        rd_ptr  <= ptr_inc(rd_ptr);
                        rd_load <= 1'b1;
                    end
                    RD_SHIFT: begin
                        if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
                        if (rd_load || (BURST && !hold && bit_cnt == '0)) begin
                            miso_q  <= rd_data[DATA_W-1];
                            out_sr  <= rd_data[DATA_W-2:0];
                            bit_cnt <= DATA_LAST;
                            rd_load <= 1'b0;
                        end else if (bit_cnt == '0) begin
                            hold <= 1'b1;
                        end else if (!hold) begin
                            miso_q  <= out_sr[DATA_W-2];
                            out_sr  <= out_sr << 1;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_bridge.sv
// tb_spi_ram_bridge -- directed bench for spi_ram_bridge.
// Two bridges share the same serial stimulus: a full 256-word one and a
// 200-word one (out-of-range pointers). A behavioural memory/pointer model per
// bridge produces the expected read words, which are queued when a read frame
// starts and popped as each word arrives on MISO.
module tb_spi_ram_bridge;
`ifdef SPI_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int DEPTH_A = 256;
    localparam int DEPTH_B = 200;

    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic mosi;
    int   checks   = 0;
    int   failures = 0;

    spi_ram_bridge_if bus_a ();
    spi_ram_bridge_if bus_b ();
    assign bus_a.ss_n = ss_n;
    assign bus_a.MOSI = mosi;
    assign bus_b.ss_n = ss_n;
    assign bus_b.MOSI = mosi;

    spi_ram_bridge #(.MEM_DEPTH(DEPTH_A), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    spi_ram_bridge #(.MEM_DEPTH(DEPTH_B), .ADDR_W(8), .DATA_W(8)) dut_small (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_a [DEPTH_A];
    logic [7:0] mem_b [DEPTH_B];
    int         wp_a, rp_a, wp_b, rp_b;
    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int p, input int depth);
        return (p >= depth - 1) ? 0 : p + 1;
    endfunction

    task automatic model_write(input logic [7:0] d);
        if (wp_a < DEPTH_A) mem_a[wp_a] = d;
        wp_a = nxt(wp_a, DEPTH_A);
        if (wp_b < DEPTH_B) mem_b[wp_b] = d;
        wp_b = nxt(wp_b, DEPTH_B);
    endtask

    task automatic model_read(output logic [7:0] da, output logic [7:0] db);
        da   = (rp_a < DEPTH_A) ? mem_a[rp_a] : 8'h00;
        rp_a = nxt(rp_a, DEPTH_A);
        db   = (rp_b < DEPTH_B) ? mem_b[rp_b] : 8'h00;
        rp_b = nxt(rp_b, DEPTH_B);
    endtask

    // Drive on the falling edge; the next rising edge samples it.
    task automatic drive(input logic s, input logic m);
        @(negedge clk);
        ss_n = s;
        mosi = m;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) drive(1'b0, b[i]);
    endtask

    task automatic start_frame(input logic [1:0] c);
        drive(1'b0, 1'b0);                       // E0
        @(negedge clk);
        check("busy_a_start", 8'(bus_a.busy), 8'h01);
        check("busy_b_start", 8'(bus_b.busy), 8'h01);
        mosi = c[1];                             // E1
        drive(1'b0, c[0]);                       // E2
    endtask

    task automatic end_frame(input logic exp_err, input string tag);
        drive(1'b1, 1'b0);
        @(negedge clk);
        check({tag, "_busy_a"}, 8'(bus_a.busy), 8'h00);
        check({tag, "_busy_b"}, 8'(bus_b.busy), 8'h00);
        check({tag, "_err_a"}, 8'(bus_a.frame_err), 8'(exp_err));
        check({tag, "_err_b"}, 8'(bus_b.frame_err), 8'(exp_err));
        check({tag, "_miso_a"}, 8'(bus_a.MISO), 8'h00);
        @(negedge clk);
        check({tag, "_err_a_gone"}, 8'(bus_a.frame_err), 8'h00);
        check({tag, "_err_b_gone"}, 8'(bus_b.frame_err), 8'h00);
    endtask

    task automatic set_ptr(input logic [1:0] c, input logic [7:0] addr);
        start_frame(c);
        send_bits(addr, 8);
        end_frame(1'b0, "addr");
        if (c[1]) begin
            rp_a = int'(addr);
            rp_b = int'(addr);
        end else begin
            wp_a = int'(addr);
            wp_b = int'(addr);
        end
    endtask

    task automatic write_frame(input logic [7:0] w0, input logic [7:0] w1, input int n);
        start_frame(2'b01);
        send_bits(w0, 8);
        model_write(w0);
        if (n > 1) begin
            send_bits(w1, 8);
            if (BURST) model_write(w1);
        end
        end_frame(1'b0, "wr");
    endtask

    task automatic read_frame(input int n, input string tag);
        logic [7:0] ea, eb, got_a, got_b;
        for (int k = 0; k < n; k++) begin
            if (k == 0 || BURST) model_read(ea, eb);
            else begin
                ea = 8'h00;
                eb = 8'h00;
            end
            exp_q_a.push_back(ea);
            exp_q_b.push_back(eb);
        end
        if (BURST) model_read(ea, eb);           // prefetch during the last word
        start_frame(2'b11);
        drive(1'b0, 1'b0);                       // E3 fetch
        @(negedge clk);
        check({tag, "_turn_a"}, 8'(bus_a.MISO), 8'h00);
        check({tag, "_turn_b"}, 8'(bus_b.MISO), 8'h00);
        got_a = 8'h00;
        got_b = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);                  // MISO sampled by master on next edge
                got_a = {got_a[6:0], bus_a.MISO};
                got_b = {got_b[6:0], bus_b.MISO};
            end
            check($sformatf("%s_a_w%0d", tag, k), got_a, exp_q_a.pop_front());
            check($sformatf("%s_b_w%0d", tag, k), got_b, exp_q_b.pop_front());
        end
        end_frame(1'b0, tag);
    endtask

    initial begin
        rst  = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        wp_a = 0; rp_a = 0; wp_b = 0; rp_b = 0;
        repeat (2) @(negedge clk);
        check("rst_miso_a", 8'(bus_a.MISO), 8'h00);
        check("rst_busy_a", 8'(bus_a.busy), 8'h00);
        check("rst_err_a", 8'(bus_a.frame_err), 8'h00);
        check("rst_miso_b", 8'(bus_b.MISO), 8'h00);
        check("rst_busy_b", 8'(bus_b.busy), 8'h00);
        check("rst_err_b", 8'(bus_b.frame_err), 8'h00);
        rst = 1'b0;

        // Basic write then streamed read.
        set_ptr(2'b00, 8'h10);
        write_frame(8'hA5, 8'h3C, 2);
        set_ptr(2'b10, 8'h10);
        read_frame(2, "rd10");

        // Pointer wrap at the top of memory.
        set_ptr(2'b00, 8'hFF);
        write_frame(8'h11, 8'h22, 2);
        set_ptr(2'b10, 8'hFF);
        read_frame(2, "rdff");

        // Abort after 5 bits of a write word: no write, error pulse.
        set_ptr(2'b00, 8'h10);
        start_frame(2'b01);
        send_bits(8'hFF, 5);
        end_frame(1'b1, "wr_abort");
        set_ptr(2'b10, 8'h10);
        read_frame(1, "rd_after_abort");

        // Abort inside the command field.
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        end_frame(1'b1, "cmd_abort");

        // Out-of-range addresses on the 200-word bridge.
        set_ptr(2'b00, 8'hC8);
        write_frame(8'h77, 8'h88, 2);
        set_ptr(2'b10, 8'hC8);
        read_frame(2, "rdc8");

        // Single-word vs burst behaviour around 0x20.
        set_ptr(2'b00, 8'h21);
        write_frame(8'h99, 8'h00, 1);
        set_ptr(2'b00, 8'h20);
        write_frame(8'hA5, 8'h3C, 2);
        set_ptr(2'b10, 8'h21);
        read_frame(1, "rd21");
        write_frame(8'h44, 8'h00, 1);
        set_ptr(2'b10, 8'h21);
        read_frame(2, "rd21b");

        // Reset on the commit edge of a write word.
        set_ptr(2'b00, 8'h00);
        write_frame(8'hE1, 8'h00, 1);
        set_ptr(2'b00, 8'h00);
        start_frame(2'b01);
        send_bits(8'h5A, 7);
        @(negedge clk);
        rst  = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        check("rstw_miso_a", 8'(bus_a.MISO), 8'h00);
        check("rstw_busy_a", 8'(bus_a.busy), 8'h00);
        check("rstw_busy_b", 8'(bus_b.busy), 8'h00);
        check("rstw_err_a", 8'(bus_a.frame_err), 8'h00);
        rst  = 1'b0;
        ss_n = 1'b1;
        wp_a = 0; rp_a = 0; wp_b = 0; rp_b = 0;
        drive(1'b1, 1'b0);
        read_frame(1, "rd_post_rst");
        write_frame(8'h66, 8'h00, 1);
        set_ptr(2'b10, 8'h00);
        read_frame(1, "rd_wp_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
